// File: rtl/multi_dataflow_job_fsm_pkg.sv
// Shared types and stream index map for the multi_dataflow job sequencer.
// The stream order is fixed in hardware: in_pel, in_size, out_pel.
package multi_dataflow_job_fsm_pkg;

  localparam int ADDR_W_DEF    = 32;
  localparam int LEN_W_DEF     = 16;
  localparam int N_STREAMS_DEF = 3;

  localparam int STREAM_IN_PEL  = 0;
  localparam int STREAM_IN_SIZE = 1;
  localparam int STREAM_OUT_PEL = 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RUN,
    DONE
  } job_state_e;

  typedef struct packed {
    logic [N_STREAMS_DEF-1:0][ADDR_W_DEF-1:0] addr;
    logic [LEN_W_DEF-1:0]                     len;
  } job_cfg_t;

  // The size stream carries a single word; pel streams carry the job length.
  function automatic logic one_word_stream(input int idx);
    case (idx)
      STREAM_IN_PEL, STREAM_OUT_PEL: return 1'b0;
      STREAM_IN_SIZE:                return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multi_dataflow_job_fsm_req_slot.sv
// One address-generator request channel: holds addr/len for the job and
// keeps valid high until its own ready has been seen once.
module multi_dataflow_req_slot #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_active,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic [LEN_W-1:0]  o_len,
  output logic              o_accepted
);

  logic r_accepted;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_accepted <= 1'b0;
      o_addr     <= '0;
      o_len      <= '0;
    end else if (i_clear) begin
      r_accepted <= 1'b0;
    end else if (i_load) begin
      r_accepted <= 1'b0;
      o_addr     <= i_addr;
      o_len      <= i_len;
    end else if (o_valid && i_ready) begin
      r_accepted <= 1'b1;
    end
  end

  assign o_valid = i_active && !r_accepted;

  // Includes an accept happening this cycle so the FSM can advance at once.
  assign o_accepted = r_accepted || (o_valid && i_ready);

endmodule

// File: rtl/multi_dataflow_job_fsm.sv
// Job sequencer: latches a descriptor, issues one request per stream, starts
// the engine and counts stream handshakes until the job has fully drained.
module multi_dataflow_job_fsm
  import multi_dataflow_job_fsm_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int N_STREAMS = N_STREAMS_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [N_STREAMS*ADDR_W-1:0]   cfg_addr_i,
  input  logic [LEN_W-1:0]              cfg_len_i,
  output logic [N_STREAMS-1:0]          req_valid_o,
  input  logic [N_STREAMS-1:0]          req_ready_i,
  output logic [N_STREAMS*ADDR_W-1:0]   req_addr_o,
  output logic [N_STREAMS*LEN_W-1:0]    req_len_o,
  input  logic                          in_hs_i,
  input  logic                          out_hs_i,
  output logic                          engine_start_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          evt_o,
  output logic                          err_o,
  output logic [LEN_W-1:0]              out_cnt_o
);

  job_state_e           r_state;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_in_cnt;
  logic [N_STREAMS-1:0] w_acc;
  logic                 w_load;
  logic                 w_in_sat;
  logic                 w_out_sat;
  logic                 w_err_set;
  logic [LEN_W-1:0]     w_in_next;
  logic [LEN_W-1:0]     w_out_next;

  assign w_load = (r_state == IDLE) && start_i;

  for (genvar g = 0; g < N_STREAMS; g++) begin : g_slot
    logic [LEN_W-1:0] w_slot_len;
    assign w_slot_len = one_word_stream(g) ? LEN_W'(1) : cfg_len_i;

    multi_dataflow_req_slot #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_slot (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_clear    (clear_i),
      .i_load     (w_load),
      .i_active   (r_state == REQ),
      .i_addr     (cfg_addr_i[g*ADDR_W +: ADDR_W]),
      .i_len      (w_slot_len),
      .i_ready    (req_ready_i[g]),
      .o_valid    (req_valid_o[g]),
      .o_addr     (req_addr_o[g*ADDR_W +: ADDR_W]),
      .o_len      (req_len_o[g*LEN_W +: LEN_W]),
      .o_accepted (w_acc[g])
    );
  end

  // Counters saturate at len so a full-scale job never wraps.
  assign w_in_sat   = (r_in_cnt == r_len);
  assign w_out_sat  = (out_cnt_o == r_len);
  assign w_in_next  = (in_hs_i && !w_in_sat) ? r_in_cnt + LEN_W'(1) : r_in_cnt;
  assign w_out_next = (out_hs_i && !w_out_sat) ? out_cnt_o + LEN_W'(1) : out_cnt_o;

  assign w_err_set = (start_i && (r_state != IDLE))
                  || ((in_hs_i || out_hs_i) && (r_state != RUN))
                  || ((r_state == RUN) && ((in_hs_i && w_in_sat) || (out_hs_i && w_out_sat)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= IDLE;
      r_len          <= '0;
      r_in_cnt       <= '0;
      out_cnt_o      <= '0;
      engine_start_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      evt_o          <= 1'b0;
      err_o          <= 1'b0;
    end else if (clear_i) begin
      r_state        <= IDLE;
      r_in_cnt       <= '0;
      out_cnt_o      <= '0;
      engine_start_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      evt_o          <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      engine_start_o <= 1'b0;
      done_o         <= 1'b0;
      evt_o          <= 1'b0;
      err_o          <= err_o || w_err_set;
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_len     <= cfg_len_i;
            r_in_cnt  <= '0;
            out_cnt_o <= '0;
            err_o     <= w_err_set;
            if (cfg_len_i == '0) begin
              r_state <= DONE;
              busy_o  <= 1'b0;
            end else begin
              r_state <= REQ;
              busy_o  <= 1'b1;
            end
          end
        end
        REQ: begin
          if (&w_acc) begin
            r_state        <= RUN;
            engine_start_o <= 1'b1;
          end
        end
        RUN: begin
          r_in_cnt  <= w_in_next;
          out_cnt_o <= w_out_next;
          if ((w_in_next == r_len) && (w_out_next == r_len)) begin
            r_state <= DONE;
            busy_o  <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          done_o  <= 1'b1;
          evt_o   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_dataflow_job_fsm.sv
// Bench for the job sequencer: directed scenarios plus random traffic, all
// checked cycle by cycle against a job-level reference model.
module tb_multi_dataflow_job_fsm;

  logic        clk = 1'b0;
  logic        rst, clr, st, ih, oh;
  logic [2:0]  rdy;
  logic [31:0] cfgAddr [3];
  logic [15:0] cfgLen;
  logic [95:0] cfgAddrBus;

  logic [2:0]  req_valid_o;
  logic [95:0] req_addr_o;
  logic [47:0] req_len_o;
  logic        engine_start_o, busy_o, done_o, evt_o, err_o;
  logic [15:0] out_cnt_o;

  int total = 0;
  int bad = 0;

  // Reference model: job-level bookkeeping of what the sequencer should show.
  bit          mIdle, mRunning, mFinishing, mErr, mStart, mDone, mBusy;
  bit [2:0]    mPending;
  int          mJobLen, mInCnt, mOutCnt;
  logic [31:0] mAddr [3];
  logic [15:0] mLen [3];

  assign cfgAddrBus = {cfgAddr[2], cfgAddr[1], cfgAddr[0]};

  always #5 clk = ~clk;

  multi_dataflow_job_fsm dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clear_i        (clr),
    .start_i        (st),
    .cfg_addr_i     (cfgAddrBus),
    .cfg_len_i      (cfgLen),
    .req_valid_o    (req_valid_o),
    .req_ready_i    (rdy),
    .req_addr_o     (req_addr_o),
    .req_len_o      (req_len_o),
    .in_hs_i        (ih),
    .out_hs_i       (oh),
    .engine_start_o (engine_start_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .evt_o          (evt_o),
    .err_o          (err_o),
    .out_cnt_o      (out_cnt_o)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function void modelReset();
    mIdle = 1; mRunning = 0; mFinishing = 0; mErr = 0; mStart = 0; mDone = 0; mBusy = 0;
    mPending = 0; mJobLen = 0; mInCnt = 0; mOutCnt = 0;
    for (int k = 0; k < 3; k++) begin
      mAddr[k] = '0;
      mLen[k] = '0;
    end
  endfunction

  function void modelStep(input bit r, input bit c, input bit s, input logic [2:0] rd, input bit i, input bit o);
    bit errNow;
    if (r) begin
      modelReset();
      return;
    end
    if (c) begin
      mIdle = 1; mRunning = 0; mFinishing = 0; mPending = 0;
      mInCnt = 0; mOutCnt = 0; mErr = 0; mStart = 0; mDone = 0; mBusy = 0;
      return;
    end
    errNow = 0;
    mStart = 0;
    mDone = 0;
    if (mIdle) begin
      if (i || o) errNow = 1;
      if (s) begin
        for (int k = 0; k < 3; k++) mAddr[k] = cfgAddr[k];
        mLen[0] = cfgLen;
        mLen[1] = 16'd1;
        mLen[2] = cfgLen;
        mJobLen = int'(cfgLen);
        mInCnt = 0;
        mOutCnt = 0;
        mErr = 0;
        mIdle = 0;
        if (cfgLen == 0) begin
          mFinishing = 1;
          mBusy = 0;
        end else begin
          mPending = 3'b111;
          mBusy = 1;
        end
      end
    end else if (mPending != 0) begin
      if (s || i || o) errNow = 1;
      mPending = mPending & ~rd;
      if (mPending == 0) begin
        mRunning = 1;
        mStart = 1;
      end
    end else if (mRunning) begin
      if (s) errNow = 1;
      if (i) begin
        if (mInCnt == mJobLen) errNow = 1;
        else mInCnt++;
      end
      if (o) begin
        if (mOutCnt == mJobLen) errNow = 1;
        else mOutCnt++;
      end
      if (mInCnt == mJobLen && mOutCnt == mJobLen) begin
        mRunning = 0;
        mFinishing = 1;
        mBusy = 0;
      end
    end else if (mFinishing) begin
      if (s || i || o) errNow = 1;
      mFinishing = 0;
      mIdle = 1;
      mDone = 1;
    end
    mErr = mErr | errNow;
  endfunction

  task automatic checkAll();
    checkOutput("req_valid", req_valid_o, mPending);
    checkOutput("busy", busy_o, mBusy);
    checkOutput("engine_start", engine_start_o, mStart);
    checkOutput("done", done_o, mDone);
    checkOutput("evt", evt_o, mDone);
    checkOutput("err", err_o, mErr);
    checkOutput("out_cnt", out_cnt_o, mOutCnt[15:0]);
    checkOutput("req_addr", req_addr_o, {mAddr[2], mAddr[1], mAddr[0]});
    checkOutput("req_len", req_len_o, {mLen[2], mLen[1], mLen[0]});
  endtask

  // One clock: check what the DUT shows now, then drive and advance the model.
  task automatic applyStimulus(input bit r, input bit c, input bit s, input logic [2:0] rd, input bit i, input bit o);
    @(negedge clk);
    checkAll();
    rst = r; clr = c; st = s; rdy = rd; ih = i; oh = o;
    modelStep(r, c, s, rd, i, o);
    @(posedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 3'b000, 0, 0);
  endtask

  task automatic setJob(input logic [15:0] len, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    cfgLen = len;
    cfgAddr[0] = a0;
    cfgAddr[1] = a1;
    cfgAddr[2] = a2;
  endtask

  initial begin
    bit r, c, s, i, o;
    logic [2:0] rd;

    rst = 1; clr = 0; st = 0; rdy = 0; ih = 0; oh = 0;
    setJob(16'd0, 32'd0, 32'd0, 32'd0);
    modelReset();
    repeat (2) @(posedge clk);
    applyStimulus(1, 0, 0, 3'b000, 0, 0);
    #1;
    checkOutput("reset_busy", busy_o, 1'b0);
    checkOutput("reset_outcnt", out_cnt_o, 16'd0);
    idleCycles(2);

    // Basic job, all readies high.
    setJob(16'd4, 32'h100, 32'h200, 32'h300);
    applyStimulus(0, 0, 1, 3'b000, 0, 0);
    #1;
    checkOutput("basic_valid_t1", req_valid_o, 3'b111);
    checkOutput("basic_len_t1", req_len_o, {16'd4, 16'd1, 16'd4});
    checkOutput("basic_addr_t1", req_addr_o, {32'h300, 32'h200, 32'h100});
    applyStimulus(0, 0, 0, 3'b111, 0, 0);
    #1;
    checkOutput("basic_estart_t2", engine_start_o, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 3'b000, 1, 1);
    #1;
    checkOutput("basic_outcnt", out_cnt_o, 16'd4);
    applyStimulus(0, 0, 0, 3'b000, 0, 0);
    #1;
    checkOutput("basic_done", done_o, 1'b1);
    checkOutput("basic_busy_done", busy_o, 1'b0);
    idleCycles(2);

    // Staggered readies.
    setJob(16'd4, 32'hA00, 32'hB00, 32'hC00);
    applyStimulus(0, 0, 1, 3'b000, 0, 0);
    applyStimulus(0, 0, 0, 3'b001, 0, 0);
    #1;
    checkOutput("stagger_valid_after_pel", req_valid_o, 3'b110);
    applyStimulus(0, 0, 0, 3'b000, 0, 0);
    applyStimulus(0, 0, 0, 3'b010, 0, 0);
    #1;
    checkOutput("stagger_valid_after_size", req_valid_o, 3'b100);
    applyStimulus(0, 0, 0, 3'b000, 0, 0);
    applyStimulus(0, 0, 0, 3'b100, 0, 0);
    #1;
    checkOutput("stagger_estart", engine_start_o, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 3'b000, 1, 1);
    idleCycles(3);

    // Zero-length job.
    setJob(16'd0, 32'h10, 32'h20, 32'h30);
    applyStimulus(0, 0, 1, 3'b111, 0, 0);
    #1;
    checkOutput("len0_valid", req_valid_o, 3'b000);
    applyStimulus(0, 0, 0, 3'b111, 0, 0);
    #1;
    checkOutput("len0_done", done_o, 1'b1);
    checkOutput("len0_err", err_o, 1'b0);
    idleCycles(3);

    // Clear in the middle of a run, then a short job.
    setJob(16'd4, 32'h1000, 32'h2000, 32'h3000);
    applyStimulus(0, 0, 1, 3'b000, 0, 0);
    applyStimulus(0, 0, 0, 3'b111, 0, 0);
    for (int k = 0; k < 2; k++) applyStimulus(0, 0, 0, 3'b000, 1, 1);
    applyStimulus(0, 1, 1, 3'b000, 0, 0);
    #1;
    checkOutput("clear_busy", busy_o, 1'b0);
    checkOutput("clear_outcnt", out_cnt_o, 16'd0);
    idleCycles(3);
    setJob(16'd1, 32'h4, 32'h8, 32'hC);
    applyStimulus(0, 0, 1, 3'b000, 0, 0);
    applyStimulus(0, 0, 0, 3'b111, 0, 0);
    applyStimulus(0, 0, 0, 3'b000, 1, 1);
    applyStimulus(0, 0, 0, 3'b000, 0, 0);
    #1;
    checkOutput("after_clear_done", done_o, 1'b1);
    idleCycles(2);

    // Start during run plus a surplus out handshake.
    setJob(16'd2, 32'h50, 32'h60, 32'h70);
    applyStimulus(0, 0, 1, 3'b000, 0, 0);
    applyStimulus(0, 0, 0, 3'b111, 0, 0);
    applyStimulus(0, 0, 0, 3'b000, 0, 1);
    applyStimulus(0, 0, 0, 3'b000, 0, 1);
    applyStimulus(0, 0, 1, 3'b000, 0, 1);
    #1;
    checkOutput("err_sticky", err_o, 1'b1);
    checkOutput("err_outcnt_sat", out_cnt_o, 16'd2);
    applyStimulus(0, 0, 0, 3'b000, 1, 0);
    applyStimulus(0, 0, 0, 3'b000, 1, 0);
    idleCycles(3);
    setJob(16'd1, 32'h1, 32'h2, 32'h3);
    applyStimulus(0, 0, 1, 3'b000, 0, 0);
    #1;
    checkOutput("err_cleared_by_start", err_o, 1'b0);
    applyStimulus(0, 0, 0, 3'b111, 0, 0);
    applyStimulus(0, 0, 0, 3'b000, 1, 1);
    idleCycles(3);

    // Reset while requests are outstanding.
    setJob(16'd3, 32'h77, 32'h88, 32'h99);
    applyStimulus(0, 0, 1, 3'b000, 0, 0);
    applyStimulus(0, 0, 0, 3'b000, 0, 0);
    applyStimulus(1, 0, 0, 3'b111, 0, 0);
    #1;
    checkOutput("rst_req_valid", req_valid_o, 3'b000);
    checkOutput("rst_req_estart", engine_start_o, 1'b0);
    idleCycles(3);

    // Full-scale length completes without wrapping.
    setJob(16'hFFFF, 32'hDEAD0000, 32'hBEEF0000, 32'hCAFE0000);
    applyStimulus(0, 0, 1, 3'b000, 0, 0);
    applyStimulus(0, 0, 0, 3'b111, 0, 0);
    for (int k = 0; k < 65535; k++) applyStimulus(0, 0, 0, 3'b000, 1, 1);
    #1;
    checkOutput("maxlen_outcnt", out_cnt_o, 16'hFFFF);
    idleCycles(3);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 79) == 0);
      s = mIdle ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      if (mIdle && s) begin
        setJob(16'($urandom_range(0, 5)), $urandom, $urandom, $urandom);
      end
      rd = 3'($urandom_range(0, 7));
      i = mRunning ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      o = mRunning ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      applyStimulus(r, c, s, rd, i, o);
    end
    idleCycles(5);

    @(negedge clk);
    checkAll();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_dataflow_job_fsm.md
Name: multi_dataflow_job_fsm

Overview:
Job sequencer between the multi_dataflow register-file controller and its streamer/engine pair. It latches a job descriptor on a trigger and issues address-generator requests for the in_pel, in_size and out_pel streams. It then starts the engine and counts stream handshakes until the job completes, then raises a one-cycle done/event.

Parameters:
ADDR_W, 32, width of TCDM byte addresses in stream requests
LEN_W, 16, width of job length (words) and of handshake counters
N_STREAMS, 3, request channels; fixed index map 0=in_pel, 1=in_size, 2=out_pel

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
clear_i  in  1  synchronous soft clear from controller
start_i  in  1  job trigger pulse
cfg_addr_i  in  N_STREAMS*ADDR_W  base address per stream
cfg_len_i  in  LEN_W  job length in 32-bit words (pels)
req_valid_o  out  N_STREAMS  per-stream request valid
req_ready_i  in  N_STREAMS  per-stream request accept
req_addr_o  out  N_STREAMS*ADDR_W  latched base address per stream
req_len_o  out  N_STREAMS*LEN_W  words: len for in_pel/out_pel, 1 for in_size
in_hs_i  in  1  in_pel stream handshake (valid&ready)
out_hs_i  in  1  out_pel stream handshake (valid&ready)
engine_start_o  out  1  one-cycle engine start pulse
busy_o  out  1  job in progress
done_o  out  1  one-cycle completion pulse
evt_o  out  1  one-cycle event, equal to done_o
err_o  out  1  sticky protocol error
out_cnt_o  out  LEN_W  out_pel words completed

Behaviour:
- Reset: state IDLE. All outputs 0. Counters and latched config 0.
- Priority: rst_i > clear_i > everything else.
- clear_i: go to IDLE next cycle. Zero counters, err_o and req_valid_o. No done_o. Applies in every state. If start_i and clear_i are high together, clear wins and start is dropped.
- States: IDLE, REQ, RUN, DONE. All outputs are registered except req_valid_o, which is decoded from state and accept bits.
- IDLE: busy_o=0. On start_i:
  - latch cfg_addr_i and cfg_len_i
  - clear err_o and counters
  - if cfg_len_i==0, go to DONE; else go to REQ
- REQ: busy_o=1.
  - req_valid_o[i] = 1 until its own req_ready_i[i] is seen; each stream has an accepted bit.
  - Valid stays high with stable addr/len until accepted.
  - When all three are accepted (including in the same cycle), go to RUN.
  - engine_start_o=1 in the first RUN cycle only.
- Latency: start_i at cycle t gives req_valid_o at t+1. If all readies are high at t+1, engine_start_o is high at t+2.
- RUN:
  - in_cnt increments on in_hs_i; out_cnt increments on out_hs_i.
  - When both counts equal len (after the update), go to DONE the next cycle.
  - in_hs_i and out_hs_i in the same cycle each count.
- DONE: done_o=evt_o=1 for exactly one cycle, busy_o=0, then IDLE. out_cnt_o holds its value until the next start.
- Errors set err_o (sticky), with no state change:
  - start_i while not IDLE: start is ignored.
  - in_hs_i or out_hs_i with the corresponding count already at len: counter saturates.
  - handshake outside RUN.
- Counter width: LEN_W. len=2^LEN_W-1 must complete without wrap.

Decomposition:
- multi_dataflow_package gains:
  - job_state_e (IDLE/REQ/RUN/DONE)
  - localparams STREAM_IN_PEL=0, STREAM_IN_SIZE=1, STREAM_OUT_PEL=2
  - job_cfg_t (addr array + len)
- One sub-module is natural: multi_dataflow_req_slot. It is one request channel (accepted bit, valid generation, addr/len hold) and is instantiated N_STREAMS times.

Test Plan:
- len=4, addrs 0x100/0x200/0x300, readies always 1, 4 in_hs and 4 out_hs:
  - req_valid_o=3'b111 at t+1, engine_start_o at t+2
  - req_len_o = {4,1,4}
  - done_o one cycle after 4th out_hs; out_cnt_o=4
- Staggered readies (in_size at t+3, out_pel at t+5, in_pel at t+1): each valid drops after its accept, and engine_start_o fires the cycle after t+5.
- len=0: no req_valid_o ever, done_o at t+2, busy_o never 1 after DONE, err_o=0.
- clear_i mid-RUN after 2 of 4 words: IDLE next cycle, counters 0, no done_o. A following len=1 job completes normally.
- start_i during RUN, plus an extra out_hs_i after count=len: err_o=1, state and counts unaffected, job completes. The next start in IDLE clears err_o.
- rst_i asserted in REQ: all outputs 0 on the following edge, with no glitch pulse on engine_start_o or done_o.
